// File: rtl/lane_collision_scanner.sv
// Time-multiplexed frog-vs-car collision scanner: snapshots the frame on i_Start,
// tests one lane per clock with half-open AABB overlap (optional screen wrap), then publishes the results.
module lane_collision_scanner #(
  parameter int NUM_LANES = 6,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int FROG_SIZE = 32,
  parameter int CAR_W     = 32,
  parameter int LANE_H    = 32,
  parameter int SCREEN_W  = 640,
  parameter int WRAP_EN   = 1,
  parameter logic [NUM_LANES*Y_W-1:0] LANE_Y =
    {9'd352, 9'd320, 9'd288, 9'd160, 9'd128, 9'd96},
  localparam int LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_Start,
  input  logic [X_W-1:0]           i_Frog_X,
  input  logic [Y_W-1:0]           i_Frog_Y,
  input  logic [NUM_LANES*X_W-1:0] i_Car_X,
  input  logic [NUM_LANES-1:0]     i_Lane_En,
  output logic                     o_Busy,
  output logic                     o_Done,
  output logic                     o_Has_Collided,
  output logic [NUM_LANES-1:0]     o_Hit_Mask,
  output logic [LANE_IDX_W-1:0]    o_Hit_Lane
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [X_W:0] CAR_W_X    = (X_W+1)'(CAR_W);
  localparam logic [X_W:0] FROG_W_X   = (X_W+1)'(FROG_SIZE);
  localparam logic [X_W:0] SCREEN_W_X = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] LANE_H_Y   = (Y_W+1)'(LANE_H);
  localparam logic [Y_W:0] FROG_H_Y   = (Y_W+1)'(FROG_SIZE);

  state_t                   r_state, w_next_state;
  logic [LANE_IDX_W-1:0]    r_lane;
  logic [X_W-1:0]           r_frog_x;
  logic [Y_W-1:0]           r_frog_y;
  logic [NUM_LANES*X_W-1:0] r_car_x;
  logic [NUM_LANES-1:0]     r_lane_en;
  logic [NUM_LANES-1:0]     r_mask;
  logic                     r_done;
  logic                     r_has_collided;
  logic [NUM_LANES-1:0]     r_hit_mask;
  logic [LANE_IDX_W-1:0]    r_hit_lane;

  // Overlap test for the lane currently addressed by r_lane, at one extra bit of width.
  logic [X_W-1:0] w_car_x;
  logic [Y_W-1:0] w_lane_y;
  logic [X_W:0]   w_fx, w_cx, w_car_right, w_frog_right;
  logic [Y_W:0]   w_fy, w_ly, w_lane_bottom, w_frog_bottom;
  logic           w_x_main, w_x_wrap, w_y_hit, w_hit;
  logic [LANE_IDX_W-1:0] w_first_hit;

  assign w_car_x       = r_car_x[int'(r_lane)*X_W +: X_W];
  assign w_lane_y      = LANE_Y[int'(r_lane)*Y_W +: Y_W];
  assign w_fx          = {1'b0, r_frog_x};
  assign w_cx          = {1'b0, w_car_x};
  assign w_fy          = {1'b0, r_frog_y};
  assign w_ly          = {1'b0, w_lane_y};
  assign w_car_right   = w_cx + CAR_W_X;
  assign w_frog_right  = w_fx + FROG_W_X;
  assign w_lane_bottom = w_ly + LANE_H_Y;
  assign w_frog_bottom = w_fy + FROG_H_Y;

  assign w_x_main = (w_fx < w_car_right) && (w_cx < w_frog_right);
  // The wrapped tail of a car re-enters at X=0 and ends at car_right-SCREEN_W.
  assign w_x_wrap = (WRAP_EN != 0) && (w_car_right > SCREEN_W_X) &&
                    (w_fx < (w_car_right - SCREEN_W_X));
  assign w_y_hit  = (w_fy < w_lane_bottom) && (w_ly < w_frog_bottom);
  assign w_hit    = r_lane_en[r_lane] && (w_x_main || w_x_wrap) && w_y_hit;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_first_hit = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (r_mask[i]) w_first_hit = LANE_IDX_W'(i);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_Start) w_next_state = SCAN;
      SCAN:    if (r_lane == LANE_IDX_W'(NUM_LANES - 1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_lane         <= '0;
      r_frog_x       <= '0;
      r_frog_y       <= '0;
      r_car_x        <= '0;
      r_lane_en      <= '0;
      r_mask         <= '0;
      r_done         <= 1'b0;
      r_has_collided <= 1'b0;
      r_hit_mask     <= '0;
      r_hit_lane     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_Start) begin
          r_frog_x  <= i_Frog_X;
          r_frog_y  <= i_Frog_Y;
          r_car_x   <= i_Car_X;
          r_lane_en <= i_Lane_En;
          r_lane    <= '0;
          r_mask    <= '0;
        end
        SCAN: begin
          r_mask[r_lane] <= w_hit;
          r_lane         <= r_lane + 1'b1;
        end
        DONE: begin
          r_done         <= 1'b1;
          r_hit_mask     <= r_mask;
          r_has_collided <= |r_mask;
          r_hit_lane     <= w_first_hit;
        end
        default: ;
      endcase
    end
  end

  assign o_Busy         = (r_state == SCAN);
  assign o_Done         = r_done;
  assign o_Has_Collided = r_has_collided;
  assign o_Hit_Mask     = r_hit_mask;
  assign o_Hit_Lane     = r_hit_lane;

endmodule

// File: tb/tb_lane_collision_scanner.sv
// Directed + random bench for lane_collision_scanner; drives a wrapping and a non-wrapping
// instance side by side and checks results from a scoreboard queue.
module tb_lane_collision_scanner;

  localparam int N  = 6;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int LY [N] = '{96, 128, 160, 288, 320, 352};

  typedef struct {
    logic [N-1:0] mask_w;
    logic [N-1:0] mask_nw;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [XW-1:0] fx;
  logic [YW-1:0] fy;
  logic [N*XW-1:0] car_x;
  logic [N-1:0]  en;

  logic          busy, done, coll;
  logic [N-1:0]  mask;
  logic [2:0]    lane;
  logic          n_busy, n_done, n_coll;
  logic [N-1:0]  n_mask;
  logic [2:0]    n_lane;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   done_cnt = 0;
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) done_cnt++;

  lane_collision_scanner #(.WRAP_EN(1)) u_dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Frog_X(fx), .i_Frog_Y(fy),
    .i_Car_X(car_x), .i_Lane_En(en), .o_Busy(busy), .o_Done(done),
    .o_Has_Collided(coll), .o_Hit_Mask(mask), .o_Hit_Lane(lane)
  );

  lane_collision_scanner #(.WRAP_EN(0)) u_nowrap (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Frog_X(fx), .i_Frog_Y(fy),
    .i_Car_X(car_x), .i_Lane_En(en), .o_Busy(n_busy), .o_Done(n_done),
    .o_Has_Collided(n_coll), .o_Hit_Mask(n_mask), .o_Hit_Lane(n_lane)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [N-1:0] m);
    lowest = 3'd0;
    for (int i = N - 1; i >= 0; i--) if (m[i]) lowest = 3'(i);
  endfunction

  function automatic logic [N-1:0] model(input int x, input int y, input logic [N*XW-1:0] cars,
                                         input logic [N-1:0] le, input bit wrap);
    logic [N-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++) begin
      int  cx;
      bit  xh, yh;
      cx = int'(cars[k*XW +: XW]);
      xh = (x < cx + 32) && (cx < x + 32);
      if (wrap && (cx + 32 > 640) && (x < cx + 32 - 640)) xh = 1'b1;
      yh = (y < LY[k] + 32) && (LY[k] < y + 32);
      m[k] = le[k] && xh && yh;
    end
    return m;
  endfunction

  task automatic set_cars(input int other, input int k, input int kx);
    for (int i = 0; i < N; i++) car_x[i*XW +: XW] = XW'(other);
    car_x[k*XW +: XW] = XW'(kx);
  endtask

  task automatic start_scan(input logic [N-1:0] mw, input logic [N-1:0] mnw);
    exp_t e;
    e.mask_w  = mw;
    e.mask_nw = mnw;
    @(negedge clk);
    sb.push_back(e);
    start = 1'b1;
    t0    = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
    e = sb.pop_front();
    check({tag, "_latency"}, cyc - t0, 7);
    check({tag, "_mask"}, mask, e.mask_w);
    check({tag, "_coll"}, coll, |e.mask_w);
    check({tag, "_lane"}, lane, lowest(e.mask_w));
    check({tag, "_nw_done"}, n_done, 1);
    check({tag, "_nw_mask"}, n_mask, e.mask_nw);
    check({tag, "_nw_coll"}, n_coll, |e.mask_nw);
    check({tag, "_nw_lane"}, n_lane, lowest(e.mask_nw));
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    fx    = '0;
    fy    = '0;
    car_x = '0;
    en    = '1;

    // Reset held for three cycles, then a start pulse while still in reset.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_coll", coll, 0);
    check("rst_mask", mask, 0);
    check("rst_lane", lane, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_start_busy0", busy, 0);
    @(negedge clk);
    check("rst_start_busy1", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic hit on lane 0.
    fx = 10'd100; fy = 9'd96; set_cars(600, 0, 90);
    start_scan(6'b000001, 6'b000001);
    wait_done("basic");

    // Edge touching versus one-pixel overlap on either side.
    fx = 10'd122; start_scan(6'b000000, 6'b000000); wait_done("touch_r");
    fx = 10'd121; start_scan(6'b000001, 6'b000001); wait_done("over_r");
    fx = 10'd58;  start_scan(6'b000000, 6'b000000); wait_done("touch_l");
    fx = 10'd59;  start_scan(6'b000001, 6'b000001); wait_done("over_l");

    // Horizontal wrap of a car on lane 3.
    fx = 10'd0; fy = 9'd288; set_cars(600, 3, 630);
    start_scan(6'b001000, 6'b000000);
    wait_done("wrap");

    // Frog straddling lanes 0 and 1, then with lane 0 disabled.
    fx = 10'd100; fy = 9'd112; set_cars(600, 0, 100); car_x[1*XW +: XW] = 10'd100;
    start_scan(6'b000011, 6'b000011); wait_done("two_lane");
    en = 6'b111110;
    start_scan(6'b000010, 6'b000010); wait_done("lane_dis");
    repeat (5) @(negedge clk);
    check("hold_mask", mask, 6'b000010);
    check("hold_lane", lane, 3'd1);

    // Inputs moved and start re-pulsed mid-scan: snapshot wins, single done.
    en = '1;
    d0 = done_cnt;
    start_scan(6'b000011, 6'b000011);
    @(negedge clk);
    @(negedge clk);
    fx    = 10'd400;
    en    = 6'b000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("snapshot");
    repeat (10) @(negedge clk);
    check("single_done", done_cnt - d0, 1);
    check("no_restart_busy", busy, 0);

    // Reset in the middle of a scan aborts it.
    fx = 10'd100; en = '1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_busy", busy, 0);
    check("abort_coll", coll, 0);
    check("abort_mask", mask, 0);
    check("abort_lane", lane, 0);

    // Random frames compared against the reference model.
    for (int r = 0; r < 8; r++) begin
      fx = XW'($urandom_range(0, 639));
      fy = YW'($urandom_range(80, 370));
      for (int i = 0; i < N; i++) car_x[i*XW +: XW] = XW'($urandom_range(0, 639));
      if (r % 2 == 0) car_x[$urandom_range(0, N - 1)*XW +: XW] = fx;
      en = N'($urandom);
      start_scan(model(int'(fx), int'(fy), car_x, en, 1'b1),
                 model(int'(fx), int'(fy), car_x, en, 1'b0));
      wait_done("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
